// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx_pkg: register offsets, STATUS bit positions and TX FSM encoding.
// UART_TX_PARITY_EN widens the state encoding to add a PARITY state.
package mmio_uart_tx_pkg;
  localparam logic [2:0] UART_TXDATA_OFS = 3'd0;
  localparam logic [2:0] UART_STATUS_OFS = 3'd4;
  localparam int ST_FULL = 0;
  localparam int ST_BUSY = 1;
  localparam int ST_OVF = 2;
  localparam int ST_COUNT_LSB = 8;
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} tx_state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;
`endif
  function automatic logic [31:0] status_word(input logic [7:0] cnt, input logic ovf,
                                              input logic busy, input logic full);
    status_word = 32'b0;
    status_word[ST_COUNT_LSB +: 8] = cnt;
    status_word[ST_OVF] = ovf;
    status_word[ST_BUSY] = busy;
    status_word[ST_FULL] = full;
  endfunction
endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with a combinational head; a push while full is
// accepted when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_din,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign o_full = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign w_pop = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);
  assign o_dout = r_mem[r_rp];
  assign o_count = r_count;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
    end else begin
      r_wp <= r_wp + AW'(w_push);
      r_rp <= r_rp + AW'(w_pop);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: data-bus bridge carving an 8-byte UART TX window out of data RAM space.
// Build option UART_TX_PARITY_EN appends an even-parity bit to each frame.
module mmio_uart_tx import mmio_uart_tx_pkg::*; #(
  parameter logic [31:0] UART_BASE = 32'h0000_FF00,
  parameter int CLK_DIV = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  input  logic [31:0] ram_rdata,
  output logic [31:0] cpu_rdata,
  output logic [3:0]  ram_be,
  output logic        txd,
  output logic        tx_busy
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DIV_M1 = CW'(CLK_DIV - 1);
  tx_state_e r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
  logic r_txd, r_ovf;
`ifdef UART_TX_PARITY_EN
  logic r_par;
`endif
  logic w_hit, w_st, w_tx, w_wr_tx, w_wr_st, w_pop, w_full, w_empty, w_busy, w_unused;
  logic [7:0] w_dout;
  logic [AW:0] w_count;
  logic [31:0] w_status;
  assign w_hit = addr[31:3] == UART_BASE[31:3];
  assign w_st = addr[2] == UART_STATUS_OFS[2];
  assign w_tx = addr[2] == UART_TXDATA_OFS[2];
  // only the lowest byte lane carries TX data, so sw to +0 and sb to +3 both push
  assign w_wr_tx = w_hit & w_tx & be[0];
  assign w_wr_st = w_hit & w_st & |be;
  assign w_pop = (r_state == S_IDLE) & ~w_empty;
  assign w_busy = (r_state != S_IDLE) | ~w_empty;
  assign w_status = status_word(8'(w_count), r_ovf, w_busy, w_full);
  assign cpu_rdata = w_hit ? (w_st ? w_status : 32'b0) : ram_rdata;
  assign ram_be = w_hit ? 4'b0000 : be;
  assign txd = r_txd;
  assign tx_busy = r_state != S_IDLE;
  assign w_unused = ^{addr[1:0], wdata[31:8]};
  uart_tx_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .i_push(w_wr_tx), .i_pop(w_pop), .i_din(wdata[7:0]),
    .o_dout(w_dout), .o_full(w_full), .o_empty(w_empty), .o_count(w_count)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ovf <= 1'b0;
    else r_ovf <= (w_wr_tx & w_full & ~w_pop) | (r_ovf & ~w_wr_st);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_txd <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (!w_empty) begin
          r_state <= S_START;
          r_cnt <= DIV_M1;
          r_shift <= w_dout;
          r_txd <= 1'b0;
`ifdef UART_TX_PARITY_EN
          r_par <= ^w_dout;
`endif
        end
        S_START: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        else begin
          r_state <= S_DATA;
          r_cnt <= DIV_M1;
          r_bit <= '0;
          r_txd <= r_shift[0];
        end
        S_DATA: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        else begin
          r_cnt <= DIV_M1;
          r_shift <= r_shift >> 1;
          r_bit <= r_bit + 1'b1;
          if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            r_state <= S_PARITY;
            r_txd <= r_par;
`else
            r_state <= S_STOP;
            r_txd <= 1'b1;
`endif
          end else r_txd <= r_shift[1];
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        else begin
          r_state <= S_STOP;
          r_cnt <= DIV_M1;
          r_txd <= 1'b1;
        end
`endif
        S_STOP: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        else r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: decode vector table, line-level UART receiver scoreboard, corner sequences.
module tb_mmio_uart_tx;
  localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11 * DIV;
`else
  localparam int FL = 10 * DIV;
`endif
  logic clk = 0, rst_n;
  logic [31:0] addr, wdata, ram_rdata, cpu_rdata;
  logic [3:0] be, ram_be;
  logic txd, tx_busy;
  int n_chk = 0, n_fail = 0, frames = 0;
  logic mon_act = 0;
  logic [7:0] q[$];
  typedef struct {
    logic [31:0] a;
    logic [3:0]  b;
    logic [31:0] rr;
    logic [3:0]  xbe;
    logic [31:0] xrd;
  } vec_t;
  vec_t v[8];

  mmio_uart_tx #(.UART_BASE(32'h0000_FF00), .CLK_DIV(DIV), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .be(be), .ram_rdata(ram_rdata),
    .cpu_rdata(cpu_rdata), .ram_be(ram_be), .txd(txd), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a; wdata = d; be = b;
    @(posedge clk); #1;
    addr = 0; wdata = 0; be = 0;
  endtask

  task automatic rd_status(input logic [31:0] exp, input string nm);
    addr = 32'hFF04; be = 0; #1;
    chk(nm, cpu_rdata, exp);
  endtask

  task automatic wait_busy(input logic val, input string nm);
    int n = 0;
    while (tx_busy !== val && n < 200) begin @(negedge clk); n++; end
    chk(nm, tx_busy, val);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end
    while ((q.size() != 0 || tx_busy || mon_act) && n < 5000);
    chk(nm, {31'b0, q.size() == 0 && !tx_busy && !mon_act}, 1);
  endtask

  // line receiver: checks every cycle of a frame against the expected bit pattern
  initial begin : mon
    logic [7:0] ex, got;
    logic [10:0] fb;
    logic ok, ab;
    forever begin
      @(negedge clk);
      if (rst_n && !txd) begin
        mon_act = 1;
        chk("frame_expected", {31'b0, q.size() != 0}, 1);
        ex = (q.size() != 0) ? q.pop_front() : 8'h00;
`ifdef UART_TX_PARITY_EN
        fb = {1'b1, ^ex, ex, 1'b0};
`else
        fb = {2'b11, ex, 1'b0};
`endif
        ok = 1; ab = 0; got = 0;
        for (int c = 0; c < FL; c++) begin
          if (c > 0) @(negedge clk);
          if (!rst_n) begin ab = 1; break; end
          if (txd !== fb[c/DIV] || tx_busy !== 1'b1) ok = 0;
          if (c % DIV == 2 && c / DIV >= 1 && c / DIV <= 8) got[c/DIV-1] = txd;
        end
        if (!ab) begin
          @(negedge clk);
          if (!rst_n) ab = 1;
          else if (txd !== 1'b1 || tx_busy !== 1'b0) ok = 0;
        end
        if (!ab) begin
          frames++;
          chk("frame_byte", {24'b0, got}, {24'b0, ex});
          chk("frame_timing", {31'b0, ok}, 1);
        end
        mon_act = 0;
      end
    end
  end

  initial begin
    rst_n = 0; addr = 0; wdata = 0; be = 0; ram_rdata = 0;
    v[0] = '{32'h0000_0010, 4'b1111, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF};
    v[1] = '{32'h0000_FF04, 4'b0000, 32'h1234_5678, 4'b0000, 32'h0000_0000};
    v[2] = '{32'h0000_FF00, 4'b0000, 32'h1234_5678, 4'b0000, 32'h0000_0000};
    v[3] = '{32'h0000_FF08, 4'b0110, 32'hCAFE_F00D, 4'b0110, 32'hCAFE_F00D};
    v[4] = '{32'h0000_FEFC, 4'b1111, 32'h0BAD_C0DE, 4'b1111, 32'h0BAD_C0DE};
    v[5] = '{32'h0000_FF07, 4'b0001, 32'h1111_1111, 4'b0000, 32'h0000_0000};
    v[6] = '{32'h0000_FF00, 4'b1000, 32'h2222_2222, 4'b0000, 32'h0000_0000};
    v[7] = '{32'h0001_FF00, 4'b0001, 32'h3333_3333, 4'b0001, 32'h3333_3333};
    repeat (3) @(negedge clk);
    chk("reset_txd", txd, 1);
    chk("reset_busy", tx_busy, 0);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      addr = v[i].a; be = v[i].b; ram_rdata = v[i].rr; #1;
      chk($sformatf("vec%0d_ram_be", i), {28'b0, ram_be}, {28'b0, v[i].xbe});
      chk($sformatf("vec%0d_rdata", i), cpu_rdata, v[i].xrd);
      @(negedge clk);
    end
    be = 0;
    rd_status(32'h0, "status_after_vectors");
    chk("idle_after_vectors", tx_busy, 0);

    // single frame with pop latency
    @(negedge clk);
    q.push_back(8'h55);
    wr(32'hFF00, 32'h0000_0055, 4'b1111);
    chk("pre_pop_txd", txd, 1);
    rd_status(32'h0000_0102, "status_queued");
    @(posedge clk); #1;
    chk("start_txd", txd, 0);
    chk("start_busy", tx_busy, 1);
    rd_status(32'h0000_0002, "status_sending");
    drain("drain_single");

    // byte stores: only lane 0 pushes
    @(negedge clk);
    addr = 32'hFF00; wdata = 32'h3C00_0000; be = 4'b1000; #1;
    chk("sb0_ram_be", {28'b0, ram_be}, 0);
    @(posedge clk); #1;
    be = 0;
    rd_status(32'h0, "sb0_no_push");
    q.push_back(8'hA5);
    wr(32'hFF03, 32'h0000_00A5, 4'b0001);
    @(posedge clk); #1;
    rd_status(32'h0000_0002, "sb3_popped");
    drain("drain_sb");

    // overflow, clear, and push-while-full with simultaneous pop
    @(negedge clk);
    q.push_back(8'h11);
    wr(32'hFF00, 32'h11, 4'b1111);
    wait_busy(1, "ovf_frame1_busy");
    q.push_back(8'h22); wr(32'hFF00, 32'h22, 4'b1111);
    q.push_back(8'h33); wr(32'hFF00, 32'h33, 4'b1111);
    q.push_back(8'h44); wr(32'hFF00, 32'h44, 4'b1111);
    q.push_back(8'h55); wr(32'hFF00, 32'h55, 4'b1111);
    rd_status(32'h0000_0403, "status_full");
    wr(32'hFF00, 32'h66, 4'b1111);
    rd_status(32'h0000_0407, "status_ovf");
    wr(32'hFF04, 32'h0, 4'b1111);
    rd_status(32'h0000_0403, "status_ovf_cleared");
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (tx_busy && n < 200);
    end
    chk("gap_idle", tx_busy, 0);
    q.push_back(8'h77);
    wr(32'hFF00, 32'h77, 4'b1111);
    rd_status(32'h0000_0403, "push_with_pop");
    drain("drain_ovf");

    // reset in the middle of a frame
    @(negedge clk);
    q.push_back(8'h0F); wr(32'hFF00, 32'h0F, 4'b1111);
    q.push_back(8'hF0); wr(32'hFF00, 32'hF0, 4'b1111);
    wait_busy(1, "rst_frame_busy");
    repeat (14) @(negedge clk);
    #2 rst_n = 0;
    q.delete();
    #1;
    chk("midrst_txd", txd, 1);
    chk("midrst_busy", tx_busy, 0);
    rd_status(32'h0, "midrst_status");
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    q.push_back(8'hC3);
    wr(32'hFF00, 32'hC3, 4'b1111);
    drain("drain_after_reset");

    // parity patterns (odd and even bit counts)
    @(negedge clk);
    q.push_back(8'h07); wr(32'hFF00, 32'h07, 4'b1111);
    q.push_back(8'h03); wr(32'hFF00, 32'h03, 4'b1111);
    drain("drain_parity");

    chk("frame_count", frames, 11);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
